// File: rtl/mandelbrot_pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mandelbrot_pipe_ctrl_pkg
// Shared types and helpers for the Mandelbrot pipeline flow controller.
//   state_e : controller state (normal streaming or end-of-frame drain)
//   clog2   : ceiling log2, used to size FIFO pointers and credit counters
// ----------------------------------------------------------------------------
package mandelbrot_pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Ceiling log2; clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mandelbrot_pipe_sync_fifo.sv
// ----------------------------------------------------------------------------
// mandelbrot_pipe_sync_fifo
// Single-clock FIFO that buffers words leaving the controlled pipeline.
// Storage is a register array; the head word is presented straight from that
// array with no fall-through, so a write into an empty FIFO shows up on the
// next cycle. rd_data reads as zero whenever the FIFO is empty.
//   aclk, areset : clock, synchronous active-high reset (pointers/count only)
//   wr_en/wr_data: push a word (must not be issued while full)
//   rd_en        : pop the head word (ignored while empty)
//   rd_data      : head word
//   full, empty  : occupancy flags
// ----------------------------------------------------------------------------
module mandelbrot_pipe_sync_fifo
    import mandelbrot_pipe_ctrl_pkg::*;
#(
    parameter int C_DWIDTH     = 32,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                wr_en,
    input  logic [C_DWIDTH-1:0] wr_data,
    input  logic                rd_en,
    output logic [C_DWIDTH-1:0] rd_data,
    output logic                full,
    output logic                empty
);

    localparam int AW = (clog2(C_FIFO_DEPTH) < 1) ? 1 : clog2(C_FIFO_DEPTH);
    localparam int CW = clog2(C_FIFO_DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(C_FIFO_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(C_FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [C_DWIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                do_wr, do_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    // Pointers wrap explicitly so any depth works, not only powers of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!do_wr && do_rd) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // The credit scheme upstream guarantees this never happens.
    a_no_write_when_full : assert property (
        @(posedge aclk) disable iff (areset) !(wr_en && full)
    ) else $fatal(1, "mandelbrot_pipe_sync_fifo: write while full");

endmodule

// File: rtl/mandelbrot_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// mandelbrot_pipe_ctrl
// Credit-based flow controller in front of a fixed-latency, enable-gated
// pipeline that has no backpressure of its own. Every accepted word reserves
// a slot in the output FIFO up front, so the pipeline output can always be
// captured and the pipeline never has to stall.
//   aclk, areset      : clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tdata : input stream
//   pipe_aclken       : clock enable to the pipeline (high only with work)
//   pipe_din          : pipeline input (s_tdata passed through)
//   pipe_dout         : pipeline output, valid C_DEPTH enabled cycles later
//   m_tvalid/m_tready/m_tdata : output stream from the FIFO head
//   flush, flush_done : end-of-frame drain request / completion pulse
//   busy              : words in flight or buffered
// ----------------------------------------------------------------------------
module mandelbrot_pipe_ctrl
    import mandelbrot_pipe_ctrl_pkg::*;
#(
    parameter int C_DWIDTH     = 32,
    parameter int C_DEPTH      = 4,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [C_DWIDTH-1:0] s_tdata,
    output logic                pipe_aclken,
    output logic [C_DWIDTH-1:0] pipe_din,
    input  logic [C_DWIDTH-1:0] pipe_dout,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [C_DWIDTH-1:0] m_tdata,
    input  logic                flush,
    output logic                flush_done,
    output logic                busy
);

    localparam int OW = clog2(C_FIFO_DEPTH + 1);
    localparam logic [OW-1:0] OCC_MAX = OW'(C_FIFO_DEPTH);
    localparam logic [OW-1:0] OCC_ONE = OW'(1);

    if ((C_FIFO_DEPTH < C_DEPTH + 1) || ((C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0)) begin : g_bad_cfg
        $error("mandelbrot_pipe_ctrl: C_FIFO_DEPTH must be a power of 2 and >= C_DEPTH+1");
    end

    state_e        state_q, state_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          s_fire, m_fire;
    logic          fifo_wr, fifo_full, fifo_empty;
    logic          any_vld;

    assign s_tready    = ~areset & (state_q == ST_RUN) & (occ_q < OCC_MAX);
    assign s_fire      = s_tvalid & s_tready;
    assign pipe_din    = s_tdata;
    assign pipe_aclken = ~areset & (s_fire | any_vld);
    assign m_tvalid    = ~fifo_empty;
    assign m_fire      = m_tvalid & m_tready;
    assign busy        = (occ_q != '0);
    // Decoded from registered state: high exactly in the DRAIN->RUN cycle.
    assign flush_done  = (state_q == ST_DRAIN) & (occ_q == '0);

    // Valid tracking mirrors the data pipeline; the tail bit flags pipe_dout.
    if (C_DEPTH == 0) begin : g_no_delay
        assign any_vld = 1'b0;
        assign fifo_wr = s_fire;
    end else begin : g_delay
        logic [C_DEPTH-1:0] vld_sr_q, vld_sr_d;

        always_comb begin
            vld_sr_d = vld_sr_q;
            if (pipe_aclken) begin
                vld_sr_d = (vld_sr_q << 1) | C_DEPTH'(s_fire);
            end
        end

        always_ff @(posedge aclk) begin
            if (areset) begin
                vld_sr_q <= '0;
            end else begin
                vld_sr_q <= vld_sr_d;
            end
        end

        assign any_vld = |vld_sr_q;
        assign fifo_wr = vld_sr_q[C_DEPTH-1] & pipe_aclken;
    end

    // Credits: a word holds its slot from acceptance until it leaves the FIFO.
    always_comb begin
        occ_d = occ_q;
        if (s_fire && !m_fire) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!s_fire && m_fire) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (occ_q == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_RUN;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
        end
    end

    mandelbrot_pipe_sync_fifo #(
        .C_DWIDTH     (C_DWIDTH),
        .C_FIFO_DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (fifo_wr),
        .wr_data (pipe_dout),
        .rd_en   (m_tready),
        .rd_data (m_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A full FIFO means every credit is held by a buffered word.
    a_full_implies_no_credit : assert property (
        @(posedge aclk) disable iff (areset) fifo_full |-> (occ_q == OCC_MAX)
    ) else $fatal(1, "mandelbrot_pipe_ctrl: FIFO full with credits outstanding");

endmodule

// File: tb/tb_mandelbrot_pipe_ctrl.sv
module tb_mandelbrot_pipe_ctrl;

    localparam int DW = 32;
    localparam int D  = 4;
    localparam int FD = 8;

    logic          clk;
    logic          areset;
    logic          s_tvalid, s_tready;
    logic [DW-1:0] s_tdata;
    logic          pipe_aclken;
    logic [DW-1:0] pipe_din, pipe_dout;
    logic          m_tvalid, m_tready;
    logic [DW-1:0] m_tdata;
    logic          flush, flush_done, busy;

    // Second instance exercising the zero-latency corner.
    logic          areset0;
    logic          s_tvalid0, s_tready0;
    logic [7:0]    s_tdata0;
    logic          pipe_aclken0;
    logic [7:0]    pipe_din0, pipe_dout0;
    logic          m_tvalid0, m_tready0;
    logic [7:0]    m_tdata0;
    logic          flush0, flush_done0, busy0;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mandelbrot_pipe_ctrl #(.C_DWIDTH(DW), .C_DEPTH(D), .C_FIFO_DEPTH(FD)) u_dut (
        .aclk(clk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .pipe_aclken(pipe_aclken), .pipe_din(pipe_din), .pipe_dout(pipe_dout),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .flush(flush), .flush_done(flush_done), .busy(busy)
    );

    mandelbrot_pipe_ctrl #(.C_DWIDTH(8), .C_DEPTH(0), .C_FIFO_DEPTH(2)) u_dut0 (
        .aclk(clk), .areset(areset0),
        .s_tvalid(s_tvalid0), .s_tready(s_tready0), .s_tdata(s_tdata0),
        .pipe_aclken(pipe_aclken0), .pipe_din(pipe_din0), .pipe_dout(pipe_dout0),
        .m_tvalid(m_tvalid0), .m_tready(m_tready0), .m_tdata(m_tdata0),
        .flush(flush0), .flush_done(flush_done0), .busy(busy0)
    );

    // The controlled plant: a D-stage enable-gated delay line without reset.
    logic [DW-1:0] plant [D];
    always @(posedge clk) begin
        if (pipe_aclken) begin
            plant[0] <= pipe_din;
            for (int i = 1; i < D; i++) plant[i] <= plant[i-1];
        end
    end
    assign pipe_dout  = plant[D-1];
    assign pipe_dout0 = pipe_din0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard monitor ----------------
    // Words accepted at cycle t become visible at the FIFO head at t+D+1;
    // credits = words pending + words waiting at the output.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } item_t;

    item_t         pend[$];
    logic [DW-1:0] outq[$];
    bit            draining = 0;
    bit            mon_en   = 0;
    int            mcyc     = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            int    occ;
            bit    exp_v, exp_r, sf, mf;
            item_t it;
            occ   = pend.size() + outq.size();
            exp_v = (outq.size() != 0);
            exp_r = !areset && !draining && (occ < FD);
            sf    = s_tvalid && exp_r;
            chk("m_tvalid", m_tvalid, exp_v);
            if (exp_v) chk("m_tdata", m_tdata, outq[0]);
            chk("s_tready", s_tready, exp_r);
            chk("busy", busy, occ != 0);
            chk("flush_done", flush_done, draining && occ == 0);
            chk("pipe_aclken", pipe_aclken, !areset && (sf || pend.size() != 0));
            if (areset) begin
                pend.delete();
                outq.delete();
                draining = 0;
            end else begin
                mf = exp_v && m_tready;
                if (mf) void'(outq.pop_front());
                if (!draining && flush) draining = 1;
                else if (draining && occ == 0) draining = 0;
                if (sf) begin
                    it.data = s_tdata;
                    it.due  = mcyc + D + 1;
                    pend.push_back(it);
                end
            end
            mcyc++;
            while (pend.size() != 0 && pend[0].due <= mcyc) begin
                it = pend.pop_front();
                outq.push_back(it.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        s_tvalid = 0;
        m_tready = 1;
        flush    = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        step();
        chk(name, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v, stalls, acc, pulses, n, stale;
        areset = 1; s_tvalid = 0; s_tdata = '0; m_tready = 0; flush = 0;
        areset0 = 1; s_tvalid0 = 0; s_tdata0 = '0; m_tready0 = 0; flush0 = 0;
        step();
        mon_en = 1;
        step();
        @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aclken", pipe_aclken, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_m_tdata", m_tdata, 0);
        step();
        areset = 0; areset0 = 0;
        @(negedge clk);
        chk("post_rst_s_tready", s_tready, 1);
        step();

        // Streaming 0x10..0x1F with the sink always ready.
        m_tready = 1; s_tvalid = 1; first_v = -1; stalls = 0;
        for (int i = 0; i < 26; i++) begin
            if (i < 16) s_tdata = 32'h10 + i;
            else s_tvalid = 0;
            @(negedge clk);
            if (i < 16 && !s_tready) stalls++;
            if (m_tvalid && first_v < 0) first_v = i;
            step();
        end
        chk("stream_first_latency", first_v, 5);
        chk("stream_stalls", stalls, 0);
        drain("stream_drain");

        // Backpressure: only FD credits exist.
        m_tready = 0; s_tvalid = 1; acc = 0;
        s_tdata = $urandom;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_tready) acc++;
            step();
            if (acc > 0) s_tdata = $urandom;
        end
        chk("bp_accepted", acc, FD);
        @(negedge clk);
        chk("bp_tready_low", s_tready, 0);
        step();
        // occ=8: one read alone frees a credit.
        m_tready = 1;
        @(negedge clk);
        chk("sim_full_tready", s_tready, 0);
        step();
        s_tdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("sim_credit_back", s_tready, 1);
        step();
        // Both fired last edge: occ remains 7, one more accept fills it.
        m_tready = 0; s_tdata = 32'hCAFE_0002;
        @(negedge clk);
        chk("sim_both_fire_occ7", s_tready, 1);
        step();
        s_tdata = 32'hCAFE_0003;
        @(negedge clk);
        chk("sim_refill_full", s_tready, 0);
        step();
        m_tready = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            s_tdata = $urandom;
        end
        drain("bp_drain");

        // Randomized traffic with occasional flush pulses.
        for (int i = 0; i < 400; i++) begin
            s_tvalid = ($urandom_range(0, 99) < 70);
            m_tready = ($urandom_range(0, 99) < 60);
            flush    = ($urandom_range(0, 49) == 0);
            s_tdata  = $urandom;
            step();
        end
        drain("rand_drain");

        // Flush after three words.
        m_tready = 1; s_tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 32'hF00 + i;
            step();
        end
        s_tvalid = 0; flush = 1;
        step();
        flush = 0; s_tvalid = 1; s_tdata = 32'hBAD;
        @(negedge clk);
        chk("flush_tready_low", s_tready, 0);
        pulses = 0; n = 0;
        while (!s_tready && n < 40) begin
            if (flush_done) pulses++;
            step();
            @(negedge clk);
            n++;
        end
        chk("flush_done_pulses", pulses, 1);
        chk("flush_back_to_run", s_tready, 1);
        step();
        drain("flush_drain");

        // Flush with nothing in flight.
        flush = 1;
        step();
        flush = 0;
        @(negedge clk);
        chk("idle_flush_done", flush_done, 1);
        chk("idle_flush_tready", s_tready, 0);
        step();
        @(negedge clk);
        chk("idle_flush_done_end", flush_done, 0);
        chk("idle_flush_run", s_tready, 1);
        step();

        // Reset with 3 buffered and 2 in flight.
        m_tready = 0; s_tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 32'h5000 + i;
            step();
        end
        s_tvalid = 0;
        for (int i = 0; i < D + 2; i++) step();
        s_tvalid = 1;
        for (int i = 0; i < 2; i++) begin
            s_tdata = 32'h6000 + i;
            step();
        end
        s_tvalid = 0; areset = 1;
        step();
        areset = 0;
        @(negedge clk);
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_aclken", pipe_aclken, 0);
        m_tready = 1; stale = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (m_tvalid) stale++;
        end
        chk("midrst_no_stale", stale, 0);
        step();

        // Zero-latency instance.
        s_tdata0 = 8'hA5; s_tvalid0 = 1; m_tready0 = 0;
        @(negedge clk);
        chk("d0_tready", s_tready0, 1);
        chk("d0_no_fallthrough", m_tvalid0, 0);
        chk("d0_aclken", pipe_aclken0, 1);
        step();
        s_tdata0 = 8'h3C;
        @(negedge clk);
        chk("d0_tvalid", m_tvalid0, 1);
        chk("d0_tdata", m_tdata0, 8'hA5);
        chk("d0_busy", busy0, 1);
        step();
        s_tvalid0 = 0;
        @(negedge clk);
        chk("d0_full_tready", s_tready0, 0);
        chk("d0_head_stable", m_tdata0, 8'hA5);
        m_tready0 = 1;
        step();
        @(negedge clk);
        chk("d0_second", m_tdata0, 8'h3C);
        chk("d0_flush_done_idle", flush_done0, 0);
        step();
        @(negedge clk);
        chk("d0_empty", m_tvalid0, 0);
        chk("d0_idle", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mandelbrot_pipe_ctrl.md
Name: mandelbrot_pipe_ctrl

Overview:
- Credit-based flow controller that feeds a fixed-depth, enable-gated delay pipeline. The pipeline itself has no backpressure.
- Accepts an AXI-Stream-style input, drives the pipeline's data and clock-enable, and captures the pipeline output into an internal skid FIFO. The pipeline therefore never needs to stall.
- Sits between the Mandelbrot work dispatcher and the pixel result stream. Also provides a flush/drain handshake for end-of-frame.

Parameters:
- C_DWIDTH, 32: payload width in bits; 1+.
- C_DEPTH, 4: latency of the controlled pipeline in aclk cycles with enable high; 0+.
- C_FIFO_DEPTH, 8: output FIFO entries; power of 2; must be >= C_DEPTH+1 (elaboration error otherwise).

Ports:
- aclk, input, 1: clock.
- areset, input, 1: synchronous, active-high reset.
- s_tvalid, input, 1: input word valid.
- s_tready, output, 1: input word accepted when s_tvalid & s_tready (s_fire).
- s_tdata, input, C_DWIDTH: input payload.
- pipe_aclken, output, 1: clock enable to the pipeline.
- pipe_din, output, C_DWIDTH: data to pipeline; equals s_tdata combinationally.
- pipe_dout, input, C_DWIDTH: pipeline output; valid C_DEPTH enabled cycles after entry.
- m_tvalid, output, 1: output word valid.
- m_tready, input, 1: downstream accept (m_fire = m_tvalid & m_tready).
- m_tdata, output, C_DWIDTH: output payload, taken from the FIFO head.
- flush, input, 1: one-cycle pulse requesting drain.
- flush_done, output, 1: one-cycle pulse when the drain completes.
- busy, output, 1: high when anything is in flight or in the FIFO.

Behaviour:
- Reset (sync, areset=1 at posedge):
  - Valid shift register, credit count, FIFO pointers and state all clear.
  - Outputs are s_tready=0, m_tvalid=0, pipe_aclken=0, flush_done=0, busy=0, m_tdata=0.
  - A reset asserted mid-operation discards all in-flight and buffered words without emitting them.
- Valid tracking:
  - vld_sr[C_DEPTH-1:0] shifts in s_fire on each cycle with pipe_aclken=1, mirroring the data pipeline.
  - The tail bit marks that pipe_dout is valid; it is written into the FIFO the same cycle.
  - For C_DEPTH=0 there is no shift register; s_fire writes pipe_dout into the FIFO directly.
- Clock enable: pipe_aclken = ~areset & (s_fire | (|vld_sr)). The pipeline idles with enable low when empty, and vld_sr holds while enable is low.
- Credits:
  - occ counts words in flight plus words in the FIFO; width clog2(C_FIFO_DEPTH+1).
  - s_fire only increments occ; m_fire only decrements; both in the same cycle leave it unchanged.
  - s_tready = (state==RUN) & (occ < C_FIFO_DEPTH). The FIFO can therefore never overflow.
  - A FIFO write while full is a fatal assertion.
- Latency:
  - A word accepted at cycle t is written into the FIFO at the end of cycle t+C_DEPTH.
  - If the FIFO was empty, m_tvalid rises at cycle t+C_DEPTH+1.
  - Order is strictly FIFO.
- FIFO behaviour:
  - m_tvalid = ~empty.
  - m_tdata is stable while m_tvalid & ~m_tready.
  - A simultaneous write and read when full is impossible by the credit rule. When empty, a write becomes visible on the next cycle (no fall-through).
- State machine (two states):
  - RUN is the reset state.
  - RUN -> DRAIN on flush=1. s_tready drops the next cycle; an s_fire in the flush cycle itself is still accepted.
  - DRAIN -> RUN when occ==0. flush_done pulses in that transition cycle.
  - flush while already in DRAIN is ignored.
  - flush when occ==0 in RUN: enter DRAIN for one cycle, then flush_done pulses.
- busy = (occ != 0).

Decomposition:
- Package mandelbrot_pipe_ctrl_pkg holds:
  - state_e enum {ST_RUN, ST_DRAIN};
  - a function returning clog2 for the pointer and occ widths.
- One sub-module: mandelbrot_pipe_sync_fifo, a synchronous single-clock FIFO. It has C_DWIDTH/C_FIFO_DEPTH parameters, registered output, and full/empty flags, with the same clock and reset ports.

Test Plan:
- Streaming: C_DEPTH=4, C_FIFO_DEPTH=8, m_tready=1; send 0x10..0x1F back-to-back.
  - Expect 16 outputs in order, first m_tvalid 5 cycles after the first s_fire.
  - s_tready stays 1 throughout.
- Backpressure: m_tready=0, stream input.
  - Exactly 8 words are accepted, then s_tready=0.
  - Release m_tready: 8 words emerge, then streaming resumes. No loss or duplication.
- Simultaneous events: at occ=8, assert m_tready for one cycle with s_tvalid=1.
  - occ reaches 7, and s_tready=1 the next cycle.
  - An s_fire and m_fire in the same cycle leave occ at 7.
- Flush: send 3 words, pulse flush one cycle after the last.
  - s_tready=0 from the next cycle; all 3 words are emitted.
  - flush_done pulses once when occ hits 0; then state returns to RUN and s_tready=1.
- Reset mid-operation: assert areset with 2 words in flight and 3 buffered.
  - Next cycle m_tvalid=0, busy=0, pipe_aclken=0.
  - No stale word appears afterward.
- C_DEPTH=0 corner: a word with s_tdata=0xA5 accepted at cycle t gives m_tvalid with m_tdata=0xA5 at t+1.
